// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared FSM state type and default operand width for the sequential divider
package div_pkg;

   localparam int unsigned DIV_NB_BIT = 24;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

endpackage : div_pkg

// File: rtl/subtractor_n.sv
// rtl/subtractor_n.sv - unsigned n-bit subtractor with borrow out
module subtractor_n #(
   parameter int unsigned width = 8
) (
   input  logic [width-1:0] a_i,
   input  logic [width-1:0] b_i,
   output logic [width-1:0] diff_o,
   output logic             borrow_o
);

   assign {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};

endmodule : subtractor_n

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - unsigned restoring divider, one quotient bit per cycle, MSB first
module div_seq_ctrl
   import div_pkg::*;
#(
   parameter int unsigned nb_bit = DIV_NB_BIT
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [nb_bit-1:0] dividend_i,
   input  logic [nb_bit-1:0] divisor_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [nb_bit-1:0] quotient_o,
   output logic [nb_bit-1:0] remainder_o,
   output logic              div_by_zero_o
);

   localparam int unsigned cnt_w = $clog2(nb_bit);

   div_state_e        state_q, state_d;
   logic [cnt_w-1:0]  cnt_q, cnt_d;
   logic [nb_bit-1:0] dvd_q, dvd_d;
   logic [nb_bit-1:0] dvs_q, dvs_d;
   logic [nb_bit-1:0] rem_q, rem_d;
   logic              dbz_q, dbz_d;
   logic              done_q, done_d;
   logic [nb_bit-1:0] quot_q, quot_d;
   logic [nb_bit-1:0] remo_q, remo_d;
   logic              dbzo_q, dbzo_d;

   logic [nb_bit:0]   sub_a;
   logic [nb_bit:0]   sub_b;
   logic [nb_bit:0]   sub_diff;
   logic              sub_borrow;
   logic [nb_bit:0]   rem_next;
   logic              rem_msb_unused;

   // dvd_q shifts left each step; freed LSBs collect the quotient bits
   assign sub_a = {rem_q, dvd_q[nb_bit-1]};
   assign sub_b = {1'b0, dvs_q};

   subtractor_n #(
      .width (nb_bit + 1)
   ) u_sub (
      .a_i      (sub_a),
      .b_i      (sub_b),
      .diff_o   (sub_diff),
      .borrow_o (sub_borrow)
   );

   // restoring step; the MSB is always zero since R < divisor
   assign rem_next       = sub_borrow ? sub_a : sub_diff;
   assign rem_msb_unused = rem_next[nb_bit];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      done_d  = 1'b0;
      quot_d  = quot_q;
      remo_d  = remo_q;
      dbzo_d  = dbzo_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               dvs_d = divisor_i;
               if (divisor_i != '0) begin
                  dvd_d   = dividend_i;
                  rem_d   = '0;
                  cnt_d   = cnt_w'(nb_bit - 1);
                  dbz_d   = 1'b0;
                  state_d = ST_RUN;
               end else begin
                  dvd_d   = '1;
                  rem_d   = dividend_i;
                  dbz_d   = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            rem_d = rem_next[nb_bit-1:0];
            dvd_d = {dvd_q[nb_bit-2:0], ~sub_borrow};
            if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            quot_d  = dvd_q;
            remo_d  = rem_q;
            dbzo_d  = dbz_q;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         done_q  <= 1'b0;
         quot_q  <= '0;
         remo_q  <= '0;
         dbzo_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         done_q  <= done_d;
         quot_q  <= quot_d;
         remo_q  <= remo_d;
         dbzo_q  <= dbzo_d;
      end
   end

   assign busy_o        = (state_q != ST_IDLE);
   assign done_o        = done_q;
   assign quotient_o    = quot_q;
   assign remainder_o   = remo_q;
   assign div_by_zero_o = dbzo_q;

endmodule : div_seq_ctrl

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - directed and random scoreboard bench for div_seq_ctrl
module tb_div_seq_ctrl;

   localparam int unsigned NB = 24;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          start_i;
   logic [NB-1:0] dividend_i;
   logic [NB-1:0] divisor_i;
   logic          busy_o;
   logic          done_o;
   logic [NB-1:0] quotient_o;
   logic [NB-1:0] remainder_o;
   logic          div_by_zero_o;

   typedef struct packed {
      logic [NB-1:0] q;
      logic [NB-1:0] r;
      logic          dbz;
      int unsigned   lat;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk_i = ~clk_i;

   div_seq_ctrl #(.nb_bit(NB)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .start_i       (start_i),
      .dividend_i    (dividend_i),
      .divisor_i     (divisor_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .quotient_o    (quotient_o),
      .remainder_o   (remainder_o),
      .div_by_zero_o (div_by_zero_o)
   );

   task automatic cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [NB-1:0] a, input logic [NB-1:0] b, input bit track);
      exp_t e;
      start_i    = 1'b1;
      dividend_i = a;
      divisor_i  = b;
      if (track) begin
         e.dbz = (b == '0);
         e.q   = e.dbz ? {NB{1'b1}} : a / b;
         e.r   = e.dbz ? a : a % b;
         e.lat = e.dbz ? 1 : NB + 1;
         sb.push_back(e);
      end
      cycle();
      start_i    = 1'b0;
      dividend_i = NB'($urandom);
      divisor_i  = NB'($urandom);
      check("done_pulse_width", done_o, 0);
   endtask

   task automatic wait_done(input string tag, input int unsigned lat0);
      exp_t        e;
      int unsigned lat;
      lat = lat0;
      while (!done_o && lat < 40) begin
         cycle();
         lat++;
      end
      if (sb.size() == 0) begin
         $display("FAIL %s scoreboard empty", tag);
         n_err++;
         return;
      end
      e = sb.pop_front();
      check({tag, "_latency"}, lat, e.lat);
      check({tag, "_done"}, done_o, 1);
      check({tag, "_quotient"}, quotient_o, e.q);
      check({tag, "_remainder"}, remainder_o, e.r);
      check({tag, "_dbz"}, div_by_zero_o, e.dbz);
      check({tag, "_busy_idle"}, busy_o, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NB-1:0] a, b;

      rst_ni     = 1'b0;
      start_i    = 1'b0;
      dividend_i = '0;
      divisor_i  = '0;
      cycle();
      cycle();
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_quotient", quotient_o, 0);
      check("rst_remainder", remainder_o, 0);
      check("rst_dbz", div_by_zero_o, 0);
      rst_ni = 1'b1;
      cycle();

      start_op(24'd100, 24'd7, 1);
      wait_done("div_100_7", 0);
      start_op(24'hFFFFFF, 24'h000001, 1);
      wait_done("div_max_1", 0);
      start_op(24'h000003, 24'h00000A, 1);
      wait_done("div_3_10", 0);
      start_op(24'd5, 24'd0, 1);
      wait_done("div_by_zero", 0);

      // second start while running must be ignored
      start_op(24'd50, 24'd3, 1);
      for (int i = 1; i <= 12; i++) begin
         check("busy_during_run", busy_o, 1);
         if (i == 10) begin
            start_i    = 1'b1;
            dividend_i = 24'd9;
            divisor_i  = 24'd9;
         end
         cycle();
         start_i = 1'b0;
      end
      wait_done("ignored_start", 12);

      // reset in RUN aborts; reset wins over a simultaneous start
      start_op(24'd50, 24'd3, 0);
      for (int i = 1; i <= 11; i++) cycle();
      rst_ni     = 1'b0;
      start_i    = 1'b1;
      dividend_i = 24'd9;
      divisor_i  = 24'd9;
      cycle();
      check("abort_busy", busy_o, 0);
      check("abort_done", done_o, 0);
      check("abort_quotient", quotient_o, 0);
      check("abort_remainder", remainder_o, 0);
      check("abort_dbz", div_by_zero_o, 0);
      rst_ni  = 1'b1;
      start_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("abort_idle_busy", busy_o, 0);
         check("abort_no_done", done_o, 0);
      end
      start_op(24'd9, 24'd9, 1);
      wait_done("after_abort", 0);

      for (int i = 0; i < 300; i++) begin
         a = NB'($urandom);
         b = NB'($urandom);
         case (i % 4)
            1: b = NB'($urandom_range(1, 15));
            2: a = NB'($urandom_range(0, 255));
            3: b = NB'($urandom) >> $urandom_range(0, NB - 1);
            default: ;
         endcase
         if (b == '0) b = 24'd1;
         start_op(a, b, 1);
         wait_done("random", 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_div_seq_ctrl
